// File: rtl/gen_rr_arb_top.sv
// Round-robin arbiter with grant lock and optional hold timeout.
// Produces a registered encoded grant index plus valid and timeout pulse.
module gen_rr_arb_top #(
  parameter int REQ_N    = 4,
  parameter int MAX_HOLD = 0,
  localparam int IDX_W   = $clog2(REQ_N),
  localparam int HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  input  logic             rel,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             gnt_tout
);

  localparam int unsigned N = REQ_N;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(REQ_N - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  ptr, next_ptr, next_idx, rel_ptr;
  logic [HOLD_W-1:0] hold_cnt, next_hold;
  logic              next_vld, next_tout, any_req, timeout;

  // First set request at or after start, wrapping at REQ_N rather than 2**IDX_W.
  function automatic logic [IDX_W-1:0] pick(input logic [REQ_N-1:0] r,
                                            input logic [IDX_W-1:0] start);
    logic        found;
    int unsigned i;
    pick  = start;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      i = 32'(start) + off;
      if (i >= N) i = i - N;
      if (!found && r[IDX_W'(i)]) begin
        pick  = IDX_W'(i);
        found = 1'b1;
      end
    end
  endfunction

  assign any_req = |req;
  assign timeout = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
  assign rel_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    next_idx   = gnt_idx;
    next_vld   = gnt_vld;
    next_tout  = 1'b0;
    next_hold  = hold_cnt;
    case (state)
      IDLE: begin
        next_vld = 1'b0;
        if (any_req) begin
          next_idx   = pick(req, ptr);
          next_vld   = 1'b1;
          next_hold  = '0;
          next_state = GRANT;
        end
      end
      GRANT: begin
        if (rel || timeout) begin
          // Re-arbitrate in the release cycle so back-to-back grants have no bubble.
          next_ptr  = rel_ptr;
          next_hold = '0;
          next_tout = !rel;
          if (any_req) begin
            next_idx = pick(req, rel_ptr);
          end else begin
            next_vld   = 1'b0;
            next_state = IDLE;
          end
        end else if (hold_cnt != '1) begin
          next_hold = hold_cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      gnt_tout <= 1'b0;
    end else begin
      state    <= next_state;
      ptr      <= next_ptr;
      hold_cnt <= next_hold;
      gnt_idx  <= next_idx;
      gnt_vld  <= next_vld;
      gnt_tout <= next_tout;
    end
  end

endmodule

// File: tb/tb_gen_rr_arb_top.sv
// Scoreboard bench: two arbiter configurations (4 req with timeout 4, 3 req no timeout)
// driven with shared directed and random stimulus, checked against a behavioural model.
module tb_gen_rr_arb_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       rel = 1'b0;

  logic [1:0] a_idx, b_idx;
  logic       a_vld, a_tout, b_vld, b_tout;

  gen_rr_arb_top #(.REQ_N(4), .MAX_HOLD(4)) u_a (
    .clk(clk), .rst(rst), .req(req), .rel(rel),
    .gnt_idx(a_idx), .gnt_vld(a_vld), .gnt_tout(a_tout)
  );

  gen_rr_arb_top #(.REQ_N(3), .MAX_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .req(req[2:0]), .rel(rel),
    .gnt_idx(b_idx), .gnt_vld(b_vld), .gnt_tout(b_tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    int idx;
    int ptr;
    int held;
    bit tout;
  } mstate_t;

  typedef struct {
    bit vld;
    int idx;
    bit tout;
  } exp_t;

  mstate_t sa, sb;
  exp_t    qa[$], qb[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  bit      done  = 0;

  // Earliest requester in circular order starting at p.
  function automatic int first_req(input bit [3:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (p + k) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input int n, input int mh,
                                         input bit rs, input bit [3:0] r, input bit rl);
    mstate_t o;
    bit [3:0] rm;
    int w;
    o = s;
    o.tout = 0;
    rm = r & 4'((1 << n) - 1);
    if (rs) begin
      o.busy = 0; o.idx = 0; o.ptr = 0; o.held = 0;
    end else if (!o.busy) begin
      w = first_req(rm, o.ptr, n);
      if (w >= 0) begin
        o.busy = 1; o.idx = w; o.held = 0;
      end
    end else if (rl || (mh > 0 && s.held + 1 == mh)) begin
      o.ptr  = (s.idx + 1) % n;
      o.held = 0;
      o.tout = !rl;
      w = first_req(rm, o.ptr, n);
      if (w >= 0) o.idx = w;
      else        o.busy = 0;
    end else begin
      o.held = s.held + 1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input bit rs, input bit [3:0] r, input bit rl);
    exp_t e;
    @(negedge clk);
    rst = rs; req = r; rel = rl;
    sa = model_step(sa, 4, 4, rs, r, rl);
    sb = model_step(sb, 3, 0, rs, r, rl);
    e.vld = sa.busy; e.idx = sa.idx; e.tout = sa.tout; qa.push_back(e);
    e.vld = sb.busy; e.idx = sb.idx; e.tout = sb.tout; qb.push_back(e);
  endtask

  // Monitor: outputs after each edge compared against the oldest queued expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_vld", int'(a_vld), int'(e.vld));
        chk("a_idx", int'(a_idx), e.idx);
        chk("a_tout", int'(a_tout), int'(e.tout));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_vld", int'(b_vld), int'(e.vld));
        chk("b_idx", int'(b_idx), e.idx);
        chk("b_tout", int'(b_tout), int'(e.tout));
      end
    end
  end

  initial begin
    sa = '{default: 0};
    sb = '{default: 0};
    // reset held with all requests, then rotation with continuous rel
    repeat (3) step(1, 4'b1111, 0);
    step(0, 4'b1111, 0);
    repeat (6) step(0, 4'b1111, 1);
    // lock and skip
    step(1, 4'b0000, 0);
    step(0, 4'b0100, 0);
    repeat (2) step(0, 4'b1001, 0);
    step(0, 4'b1001, 1);
    step(0, 4'b0001, 1);
    step(0, 4'b0000, 1);
    repeat (2) step(0, 4'b0000, 1);
    // timeout, then rel coinciding with the final hold cycle
    step(1, 4'b0000, 0);
    repeat (10) step(0, 4'b0011, 0);
    step(1, 4'b0000, 0);
    repeat (4) step(0, 4'b0011, 0);
    step(0, 4'b0011, 1);
    repeat (3) step(0, 4'b0011, 0);
    // reset mid-grant, re-grant, drop to idle, rel in idle
    step(0, 4'b0100, 1);
    step(0, 4'b0100, 0);
    step(1, 4'b0100, 0);
    step(0, 4'b0100, 0);
    step(0, 4'b0000, 0);
    step(0, 4'b0000, 1);
    repeat (3) step(0, 4'b0000, 1);
    step(0, 4'b1111, 0);
    // randomized traffic
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 99) == 0, 4'($urandom), $urandom_range(0, 3) == 0);
    step(0, 4'b0000, 0);
    @(posedge clk);
    #2;
    done = 1;
    chk("queue_drain", qa.size() + qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
